mio_arbiter: RTL

Shares the single memory/IO bus port between the multi-cycle CPU (MCPU memory interface) and the display scanner that reads the 2048 board/frame memory. Display reads get priority for real-time scanout, but the CPU gets a grant after a bounded number of consecutive display grants. A per-transaction timeout keeps either requester from hanging on a dead slave. The block sits between MCPU/display and the memory/peripheral decoder and owns all bus sequencing.

---
 rtl/mio_pkg.sv | 27 ++
 rtl/mio_timeout_ctr.sv | 27 ++
 rtl/mio_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU/display memory-bus arbiter.
package mio_pkg;

  localparam int unsigned MIO_AW = 32;
  localparam int unsigned MIO_DW = 32;

  localparam logic [MIO_DW-1:0] MIO_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_CPU = 2'd1,
    ST_BUSY_VGA = 2'd2,
    ST_RESP     = 2'd3
  } mio_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } mio_owner_e;

  typedef struct packed {
    logic              we;
    logic [MIO_AW-1:0] addr;
    logic [MIO_DW-1:0] wdata;
  } mio_req_t;

endpackage

// File: rtl/mio_timeout_ctr.sv
// Transaction watchdog: clear on grant, count wait cycles, flag the terminal count.
module mio_timeout_ctr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc_c
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc_c = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mio_arbiter.sv
// Shares the memory/IO bus between the CPU and the display scanner with
// display priority, bounded display streaks and a per-transaction timeout.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned VGA_BURST = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MIO_AW-1:0] cpu_addr,
  input  logic [MIO_DW-1:0] cpu_wdata,
  output logic [MIO_DW-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              vga_req,
  input  logic [MIO_AW-1:0] vga_addr,
  output logic [MIO_DW-1:0] vga_rdata,
  output logic              vga_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MIO_AW-1:0] mem_addr,
  output logic [MIO_DW-1:0] mem_wdata,
  input  logic [MIO_DW-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic [1:0]        state
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TMO_W    = 8;

  mio_state_e          state_q, state_d;
  mio_owner_e          owner_q;
  mio_req_t            req_q;
  logic [STREAK_W-1:0] streak_q;
  logic                grant_cpu_c, grant_vga_c;
  logic                done_ack_c, done_tmo_c;
  logic                tmo_inc_c, tmo_tc_c;
  logic [MIO_DW-1:0]   resp_data_c;

  mio_timeout_ctr #(
    .WIDTH    (TMO_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear (grant_cpu_c | grant_vga_c),
    .inc   (tmo_inc_c),
    .tc_c  (tmo_tc_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and bus sequencing; CPU wins a tie only after a full display streak.
  always_comb begin
    state_d     = state_q;
    grant_cpu_c = 1'b0;
    grant_vga_c = 1'b0;
    done_ack_c  = 1'b0;
    done_tmo_c  = 1'b0;
    tmo_inc_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && (!vga_req || streak_q == STREAK_W'(VGA_BURST))) begin
          grant_cpu_c = 1'b1;
          state_d     = ST_BUSY_CPU;
        end else if (vga_req) begin
          grant_vga_c = 1'b1;
          state_d     = ST_BUSY_VGA;
        end
      end
      ST_BUSY_CPU, ST_BUSY_VGA: begin
        if (mem_ack) begin
          done_ack_c = 1'b1;
          state_d    = ST_RESP;
        end else if (tmo_tc_c) begin
          done_tmo_c = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_inc_c = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_data_c = done_ack_c ? mem_rdata : MIO_ERR_DATA;

  // Latches, streak and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_CPU;
      req_q     <= '0;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      cpu_ready <= 1'b0;
      vga_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      vga_ready <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= (state_d == ST_BUSY_CPU) || (state_d == ST_BUSY_VGA);
      if (grant_cpu_c) begin
        owner_q     <= OWN_CPU;
        req_q.we    <= cpu_we;
        req_q.addr  <= cpu_addr;
        req_q.wdata <= cpu_wdata;
        streak_q    <= '0;
      end
      if (grant_vga_c) begin
        owner_q     <= OWN_VGA;
        req_q.we    <= 1'b0;
        req_q.addr  <= vga_addr;
        req_q.wdata <= '0;
        streak_q    <= cpu_req ? streak_q + STREAK_W'(1) : '0;
      end
      if (done_ack_c || done_tmo_c) begin
        bus_err <= done_tmo_c;
        if (owner_q == OWN_CPU) begin
          cpu_rdata <= resp_data_c;
          cpu_ready <= 1'b1;
        end else begin
          vga_rdata <= resp_data_c;
          vga_ready <= 1'b1;
        end
      end
    end
  end

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign state     = 2'(state_q);

endmodule
